sm_dma_copy: RTL
================

# sm_dma_copy

Word-granular memory copy/fill engine for the schoolMIPS data RAM. It is the master on the RAM's second port (address, write enable, write data, combinational read data), so block moves and clears run without the CPU core, which keeps the first port. The engine takes a one-cycle start command with source, destination, length and mode, runs an internal FSM, and reports completion or error with single-cycle pulses.

## Interface
- LEN_W, 16, width of the word-count input; max transfer is 2^LEN_W-1 words
- clk  in  1  system clock, all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- start  in  1  command strobe; sampled only in IDLE
- mode  in  1  0 = copy, 1 = fill
- src  in  32  source byte address (copy only)
- dst  in  32  destination byte address
- len  in  LEN_W  transfer length in 32-bit words
- fill_val  in  32  constant written in fill mode
- abort  in  1  cancel the running transfer
- busy  out  1  high while in READ or WRITE
- done  out  1  one-cycle pulse on normal completion
- err  out  1  one-cycle pulse on a rejected command
- mem_addr  out  32  RAM port-B byte address
- mem_we  out  1  RAM port-B write enable
- mem_wd  out  32  RAM port-B write data
- mem_rd  in  32  RAM port-B read data, combinational from mem_addr

## Operation
- States: IDLE, READ, WRITE, DONE. Reset puts the FSM in IDLE. Reset values: busy=0, done=0, err=0, mem_we=0, mem_addr=0, mem_wd=0, internal counters 0.
- Command latch in IDLE on start=1: src, dst, len, mode and fill_val are registered. Inputs may change afterwards without effect.
- Alignment check: src[1:0]!=0 (copy mode only) or dst[1:0]!=0 → err=1 for one cycle, FSM stays IDLE, no memory access.
- len=0 → go to DONE; no memory access.
- Copy: READ drives mem_addr=src_cur and latches mem_rd into a word buffer at the clock edge. WRITE drives mem_addr=dst_cur, mem_we=1, mem_wd=buffer. After each WRITE the remaining-word count decrements and both pointers step 4 bytes. count reaching 0 → DONE, otherwise → READ.
- Copy direction:
  - Descending when the regions overlap with dst above src: dst > src and dst < src + 4·len, with the sum and compare done in 33 bits.
  - Descending pointers start at src+4·(len−1) and dst+4·(len−1) and decrement by 4.
  - Otherwise the copy is ascending. The result must equal memmove semantics.
- Fill: WRITE only. Every cycle writes fill_val to dst_cur, always ascending; READ is never entered.
- Pointer arithmetic is modulo 2^32 (wraps past 0xFFFF_FFFC without error).
- DONE: done=1 for one cycle, busy=0, then → IDLE.
- abort=1 in READ or WRITE: mem_we is forced 0 in that same cycle, and the FSM goes to IDLE next edge with no done and no err. abort in IDLE or DONE is ignored.
- Outside a WRITE cycle: mem_we=0 and mem_wd=0. Outside READ/WRITE: mem_addr=0.
- start while busy or in DONE is ignored (not queued).
- Reset asserted mid-transfer: outputs go to reset values immediately, asynchronously; no further writes.

## Timing
- Start accepted at edge T0. First READ (or fill WRITE) occupies the cycle after T0.
- Copy of N words: busy for 2N cycles, done in cycle 2N+1 after T0. Fill: busy N cycles, done in cycle N+1.
- len=0: done in the cycle after T0; busy never asserts.
- Misaligned command: err in the cycle after T0; busy never asserts.
- Earliest next start is accepted in the cycle after done (back in IDLE).
- mem_rd is sampled only at the end of READ cycles; a RAM write on the other port to the same address in that cycle yields the old value.

## Test plan
- Ascending copy, src=0x00, dst=0x40, len=3, RAM[0..2]=A,B,C → writes at 0x40/0x44/0x48 = A,B,C on cycles 2,4,6; done on cycle 7.
- Overlapping copy, src=0x00, dst=0x04, len=4, RAM[0..3]=1,2,3,4 → descending order, final RAM[1..4]=1,2,3,4 and RAM[0]=1.
- Fill, dst=0x10, len=5, fill_val=0xDEADBEEF → five consecutive write cycles 0x10..0x20; done on cycle 6; no READ states.
- Misaligned dst=0x42 → err pulse on cycle 1; mem_we never asserted. len=0 → done on cycle 1 only.
- abort asserted in the 2nd WRITE of a len=4 copy → exactly 1 word written, busy drops, no done. Restart is then accepted.
- rst pulsed mid-copy, and start pulsed while busy → all outputs 0 immediately; the ignored start produces no effect on pointers or count.

Source files
------------

// File: rtl/sm_dma_copy.sv
// Word-granular copy/fill DMA engine mastering port B of the schoolMIPS data RAM.
// Overlapping copies with the destination above the source run descending, giving memmove results.

module sm_dma_copy #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [31:0]      src,
  input  logic [31:0]      dst,
  input  logic [LEN_W-1:0] len,
  input  logic [31:0]      fill_val,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [31:0]      mem_addr,
  output logic             mem_we,
  output logic [31:0]      mem_wd,
  input  logic [31:0]      mem_rd
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t           state;
  logic [31:0]      src_cur;
  logic [31:0]      dst_cur;
  logic [31:0]      step;
  logic [31:0]      fill_q;
  logic [LEN_W-1:0] count;
  logic             fill_mode;
  logic             we_q;

  logic             misaligned;
  logic             descending;
  logic [32:0]      src_end;
  logic [31:0]      last_off;
  logic [31:0]      src_first;
  logic [31:0]      dst_first;

  // Command decode works on the raw inputs; only the accepted values are kept.
  assign misaligned = (dst[1:0] != 2'b00) || (!mode && (src[1:0] != 2'b00));
  assign src_end    = {1'b0, src} + {{(31-LEN_W){1'b0}}, len, 2'b00};
  assign descending = !mode && (dst > src) && ({1'b0, dst} < src_end);
  assign last_off   = {{(30-LEN_W){1'b0}}, len, 2'b00} - 32'd4;
  assign src_first  = descending ? src + last_off : src;
  assign dst_first  = descending ? dst + last_off : dst;

  // abort kills the write strobe in its own cycle; the FSM unwinds on the next edge.
  assign mem_we = we_q & ~abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      src_cur   <= '0;
      dst_cur   <= '0;
      step      <= '0;
      fill_q    <= '0;
      count     <= '0;
      fill_mode <= 1'b0;
      we_q      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_addr  <= '0;
      mem_wd    <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          err  <= 1'b0;
          if (start) begin
            if (misaligned) begin
              err <= 1'b1;
            end else if (len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              fill_q    <= fill_val;
              fill_mode <= mode;
              count     <= len;
              busy      <= 1'b1;
              src_cur   <= src_first;
              dst_cur   <= dst_first;
              step      <= descending ? 32'hFFFF_FFFC : 32'd4;
              if (mode) begin
                state    <= WRITE;
                mem_addr <= dst_first;
                we_q     <= 1'b1;
                mem_wd   <= fill_val;
              end else begin
                state    <= READ;
                mem_addr <= src_first;
              end
            end
          end
        end

        READ: begin
          if (abort) begin
            state    <= IDLE;
            busy     <= 1'b0;
            count    <= '0;
            mem_addr <= '0;
          end else begin
            // mem_wd doubles as the word buffer between READ and WRITE.
            state    <= WRITE;
            mem_addr <= dst_cur;
            we_q     <= 1'b1;
            mem_wd   <= mem_rd;
          end
        end

        WRITE: begin
          if (abort) begin
            state    <= IDLE;
            busy     <= 1'b0;
            count    <= '0;
            we_q     <= 1'b0;
            mem_addr <= '0;
            mem_wd   <= '0;
          end else begin
            count   <= count - LEN_W'(1);
            src_cur <= src_cur + step;
            dst_cur <= dst_cur + step;
            if (count == LEN_W'(1)) begin
              state    <= DONE;
              busy     <= 1'b0;
              done     <= 1'b1;
              we_q     <= 1'b0;
              mem_addr <= '0;
              mem_wd   <= '0;
            end else if (fill_mode) begin
              mem_addr <= dst_cur + step;
              mem_wd   <= fill_q;
            end else begin
              state    <= READ;
              mem_addr <= src_cur + step;
              we_q     <= 1'b0;
              mem_wd   <= '0;
            end
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
